// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default datapath width.
package arith_pkg;
  localparam int unsigned ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor slice: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first through one registered borrow.
// Result, borrow-out and signed overflow are held from done until the next start.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             ovf_q;
  logic             d;
  logic             bnext;
  logic             last;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d),
    .bout (bnext)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      diff_q <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            br     <= bus.bin;
            cnt    <= '0;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          diff_q <= {d, diff_q[WIDTH-1:1]};
          br     <= bnext;
          // Final slice: d is the result MSB, so flags are computed from it directly.
          if (last) begin
            done_q <= 1'b1;
            bout_q <= bnext;
            ovf_q  <= (a_msb ^ b_msb) & (d ^ a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8, plus sweeps at WIDTH 2 and 16.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(2))  bus2 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic do_op8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = ta; bus8.b = tb; bus8.bin = tbin;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = ~ta; bus8.b = ~tb; bus8.bin = ~tbin;
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b exp 1", nm, bus8.busy); end
    repeat (7) @(posedge clk); #1;
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL %s done_early got %b exp 0", nm, bus8.done); end
    @(posedge clk); #1;
    checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", nm, bus8.done); end
    checks++; if (bus8.diff !== ed) begin errors++; $display("FAIL %s diff got %h exp %h", nm, bus8.diff, ed); end
    checks++; if (bus8.bout !== eb) begin errors++; $display("FAIL %s bout got %b exp %b", nm, bus8.bout, eb); end
    checks++; if (bus8.ovf !== eo) begin errors++; $display("FAIL %s ovf got %b exp %b", nm, bus8.ovf, eo); end
    @(posedge clk); #1;
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL %s exit busy/done got %b/%b exp 0/0", nm, bus8.busy, bus8.done); end
    checks++; if (bus8.diff !== ed) begin errors++; $display("FAIL %s diff_hold got %h exp %h", nm, bus8.diff, ed); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL reset busy/done got %b/%b exp 0/0", bus8.busy, bus8.done); end
    checks++; if (bus8.diff !== 8'h00 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin errors++; $display("FAIL reset diff/bout/ovf got %h/%b/%b exp 00/0/0", bus8.diff, bus8.bout, bus8.ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    do_op8("v5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    do_op8("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op8("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op8("v7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h23; bus8.bin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL rst_mid busy/done got %b/%b exp 0/0", bus8.busy, bus8.done); end
    checks++; if (bus8.diff !== 8'h00 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin errors++; $display("FAIL rst_mid diff/bout/ovf got %h/%b/%b exp 00/0/0", bus8.diff, bus8.bout, bus8.ovf); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_mid no_done got %b/%b exp 0/0", bus8.done, bus8.busy); end
    do_op8("after_rst", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h10; bus8.bin = 1'b1;
    @(posedge clk); #1;
    bus8.a = 8'h05; bus8.b = 8'h03; bus8.bin = 1'b0;
    repeat (8) @(posedge clk); #1;
    checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL b2b done1 got %b exp 1", bus8.done); end
    checks++; if (bus8.diff !== 8'hFF || bus8.bout !== 1'b1) begin errors++; $display("FAIL b2b res1 got %h/%b exp ff/1", bus8.diff, bus8.bout); end
    @(posedge clk); #1;
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL b2b idle busy/done got %b/%b exp 0/0", bus8.busy, bus8.done); end
    @(posedge clk); #1;
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL b2b restart busy got %b exp 1", bus8.busy); end
    bus8.start = 1'b0;
    repeat (8) @(posedge clk); #1;
    checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL b2b done2 got %b exp 1", bus8.done); end
    checks++; if (bus8.diff !== 8'h02 || bus8.bout !== 1'b0 || bus8.ovf !== 1'b0) begin errors++; $display("FAIL b2b res2 got %h/%b/%b exp 02/0/0", bus8.diff, bus8.bout, bus8.ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int done_edge = -1;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.bin = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 3) bus8.start = 1'b0;
      if (bus8.done === 1'b1) begin ndone++; done_edge = k; end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore done_count got %0d exp 1", ndone); end
    checks++; if (done_edge != 8) begin errors++; $display("FAIL ignore done_edge got %0d exp 8", done_edge); end
    checks++; if (bus8.diff !== 8'h22 || bus8.bout !== 1'b0) begin errors++; $display("FAIL ignore result got %h/%b exp 22/0", bus8.diff, bus8.bout); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ignore busy_end got %b exp 0", bus8.busy); end
  endtask

  task automatic test_sweep_w2();
    logic [1:0] va, vb, ed;
    logic       vc, eb, eo;
    logic [2:0] r;
    int         lat;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          va = 2'(ia); vb = 2'(ib); vc = 1'(ic);
          r  = {1'b0, va} - {1'b0, vb} - {2'b00, vc};
          ed = r[1:0]; eb = r[2];
          eo = (va[1] != vb[1]) && (ed[1] != va[1]);
          @(negedge clk);
          bus2.start = 1'b1; bus2.a = va; bus2.b = vb; bus2.bin = vc;
          @(posedge clk); #1;
          bus2.start = 1'b0; bus2.a = ~va; bus2.b = ~vb;
          lat = 0;
          while (bus2.done !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
          checks++; if (lat != 2) begin errors++; $display("FAIL w2 %0d-%0d-%0d latency got %0d exp 2", ia, ib, ic, lat); end
          checks++; if (bus2.diff !== ed || bus2.bout !== eb || bus2.ovf !== eo) begin
            errors++; $display("FAIL w2 %0d-%0d-%0d result got %b/%b/%b exp %b/%b/%b", ia, ib, ic, bus2.diff, bus2.bout, bus2.ovf, ed, eb, eo);
          end
          @(posedge clk);
        end
      end
    end
  endtask

  task automatic test_sweep_w16();
    logic [15:0] va, vb, ed;
    logic        vc, eb, eo;
    logic [16:0] r;
    int          lat;
    for (int n = 0; n < 16; n++) begin
      va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom);
      if (n == 0) begin va = 16'h8000; vb = 16'h0001; vc = 1'b0; end
      if (n == 1) begin va = 16'h0000; vb = 16'hFFFF; vc = 1'b1; end
      r  = {1'b0, va} - {1'b0, vb} - {16'h0000, vc};
      ed = r[15:0]; eb = r[16];
      eo = (va[15] != vb[15]) && (ed[15] != va[15]);
      @(negedge clk);
      bus16.start = 1'b1; bus16.a = va; bus16.b = vb; bus16.bin = vc;
      @(posedge clk); #1;
      bus16.start = 1'b0; bus16.a = ~va; bus16.b = ~vb;
      lat = 0;
      while (bus16.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 16) begin errors++; $display("FAIL w16 #%0d latency got %0d exp 16", n, lat); end
      checks++; if (bus16.diff !== ed || bus16.bout !== eb || bus16.ovf !== eo) begin
        errors++; $display("FAIL w16 #%0d %h-%h-%b got %h/%b/%b exp %h/%b/%b", n, va, vb, vc, bus16.diff, bus16.bout, bus16.ovf, ed, eb, eo);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.bin = 1'b0;
    bus2.start = 1'b0;  bus2.a = '0;  bus2.b = '0;  bus2.bin = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
    test_reset();
    test_vectors();
    test_reset_mid();
    test_back_to_back();
    test_ignore_start();
    test_sweep_w2();
    test_sweep_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
